// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler: stage bit
// positions, FSM state encodings and the hold/bubble masks.
package pipe_ctrl_pkg;

    localparam int StgPc    = 0;
    localparam int StgIfId  = 1;
    localparam int StgIdExe = 2;
    localparam int StgExeMem = 3;
    localparam int StgMemWb = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MC_WAIT = 2'b01,
        ST_CANCEL  = 2'b10
    } mc_state_e;

    localparam logic [4:0] StallNone  = 5'b00000;
    localparam logic [4:0] StallAll   = 5'b11111;
    localparam logic [4:0] StallFront = 5'b00111;
    localparam logic [4:0] StallFetch = 5'b00011;

    localparam logic [4:0] FlushNone   = 5'b00000;
    localparam logic [4:0] FlushExeMem = 5'b01000;
    localparam logic [4:0] FlushBranch = 5'b00110;
    localparam logic [4:0] FlushIdExe  = 5'b00100;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Enable-driven up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // increment when enabled, hold once every bit is set
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the five pipeline registers. Merges memory wait,
// multi-cycle op sequencing, taken branches and load-use into per-register
// hold and bubble controls.
//
//  state      | meaning
//  IDLE       | no multi-cycle op outstanding
//  MC_WAIT    | op issued, front end held until the mc unit reports done
//  CANCEL     | op timed out; abort pulse to mc unit, exe_mem gets a bubble
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_use_i,
    input  logic             mc_start_i,
    input  logic             mc_done_i,
    input  logic             br_taken_i,
    input  logic             ext_stall_i,
    output logic [4:0]       stall_o,
    output logic [4:0]       flush_o,
    output logic             mc_cancel_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TcntLast = TW'(MC_TIMEOUT - 1);

    mc_state_e     state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [4:0]    stall_raw, flush_raw;
    logic          cancel_raw;

    // priority decode of hazards plus FSM next state; memory wait freezes everything
    always_comb begin
        stall_raw  = StallNone;
        flush_raw  = FlushNone;
        cancel_raw = 1'b0;
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        if (ext_stall_i) begin
            stall_raw = StallAll;
        end else begin
            unique case (state_q)
                ST_CANCEL: begin
                    flush_raw  = FlushExeMem;
                    cancel_raw = 1'b1;
                    state_d    = ST_IDLE;
                end
                ST_MC_WAIT: begin
                    if (mc_done_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        stall_raw = StallFront;
                        flush_raw = FlushExeMem;
                        if (tcnt_q == TcntLast) begin
                            state_d = ST_CANCEL;
                        end else begin
                            tcnt_d = tcnt_q + TW'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (mc_start_i) begin
                        stall_raw = StallFront;
                        flush_raw = FlushExeMem;
                        state_d   = ST_MC_WAIT;
                        tcnt_d    = '0;
                    end else if (br_taken_i) begin
                        flush_raw = FlushBranch;
                    end else if (ld_use_i) begin
                        stall_raw = StallFetch;
                        flush_raw = FlushIdExe;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and timeout count registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // controls forced low during reset without waiting for a clock
    assign stall_o     = rst_i ? StallNone : stall_raw;
    assign flush_o     = rst_i ? FlushNone : flush_raw;
    assign mc_cancel_o = rst_i ? 1'b0 : cancel_raw;
    assign state_o     = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (|stall_o),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int TO    = 6;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld = 1'b0, mcs = 1'b0, mcd = 1'b0, br = 1'b0, ext = 1'b0;
    logic [4:0]    stall, flush;
    logic          cancel;
    logic [1:0]    state;
    logic [CW-1:0] scnt;

    int compared   = 0;
    int mismatched = 0;

    // reference: mode 0 idle, 1 waiting on mc unit, 2 aborting
    int m_mode = 0;
    int m_wait = 0;
    int m_scnt = 0;

    pipe_ctrl #(.MC_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ld_use_i    (ld),
        .mc_start_i  (mcs),
        .mc_done_i   (mcd),
        .br_taken_i  (br),
        .ext_stall_i (ext),
        .stall_o     (stall),
        .flush_o     (flush),
        .mc_cancel_o (cancel),
        .state_o     (state),
        .stall_cnt_o (scnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [4:0] es, ef;
        logic ec;
        es = 5'b0; ef = 5'b0; ec = 1'b0;
        if (ext) es = 5'b11111;
        else if (m_mode == 2) begin ef = 5'b01000; ec = 1'b1; end
        else if (m_mode == 1 && mcd) begin end
        else if (m_mode == 1) begin es = 5'b00111; ef = 5'b01000; end
        else if (mcs) begin es = 5'b00111; ef = 5'b01000; end
        else if (br) ef = 5'b00110;
        else if (ld) begin es = 5'b00011; ef = 5'b00100; end
        chk({tag, ".stall"}, 32'(stall), 32'(es));
        chk({tag, ".flush"}, 32'(flush), 32'(ef));
        chk({tag, ".cancel"}, 32'(cancel), 32'(ec));
        chk({tag, ".state"}, 32'(state), 32'(m_mode));
        chk({tag, ".scnt"}, 32'(scnt), 32'(m_scnt));
    endtask

    // one clock: drive just after the edge, check mid-cycle, advance model at the edge
    task automatic cycle(input string tag, input logic i_ld, input logic i_mcs,
                         input logic i_mcd, input logic i_br, input logic i_ext);
        logic any_stall;
        ld = i_ld; mcs = i_mcs; mcd = i_mcd; br = i_br; ext = i_ext;
        if (mcs && (br || m_mode != 0)) begin
            mismatched++;
            $error("FAIL illegal_stimulus mc_start with branch or outside idle");
        end
        #3;
        check_all(tag);
        any_stall = ext || (m_mode == 1 && !mcd) || (m_mode == 0 && (mcs || (!br && ld)));
        @(posedge clk);
        if (any_stall && m_scnt < CMAX) m_scnt++;
        if (!ext) begin
            case (m_mode)
                0: if (mcs) begin m_mode = 1; m_wait = 0; end
                1: if (mcd) m_mode = 0;
                   else if (m_wait == TO - 1) m_mode = 2;
                   else m_wait++;
                default: m_mode = 0;
            endcase
        end
        #1;
    endtask

    // asynchronous reset pulse between edges; outputs must clear at once
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, ".rst_stall"}, 32'(stall), 32'd0);
        chk({tag, ".rst_flush"}, 32'(flush), 32'd0);
        chk({tag, ".rst_cancel"}, 32'(cancel), 32'd0);
        chk({tag, ".rst_state"}, 32'(state), 32'd0);
        chk({tag, ".rst_scnt"}, 32'(scnt), 32'd0);
        m_mode = 0; m_wait = 0; m_scnt = 0;
        ld = 0; mcs = 0; mcd = 0; br = 0; ext = 0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic done_hold;
        logic r_ext, r_mcs, r_br, r_ld;
        @(posedge clk);
        #1;
        pulse_reset("init");

        // load-use
        cycle("lduse", 1, 0, 0, 0, 0);
        chk("lduse.cnt_after", 32'(scnt), 32'd1);
        // branch beats load-use
        cycle("br_ld", 1, 0, 0, 1, 0);

        // multi-cycle op with done after five waiting cycles
        pulse_reset("t3");
        cycle("mc_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("mc_wait", 0, 0, 0, 0, 0);
        cycle("mc_done", 0, 0, 1, 0, 0);
        chk("mc.state_idle", 32'(state), 32'd0);
        chk("mc.scnt6", 32'(scnt), 32'd6);

        // timeout with no done
        cycle("to_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < TO; i++) cycle("to_wait", 0, 0, 0, 0, 0);
        chk("to.state_cancel", 32'(state), 32'd2);
        cycle("to_cancel", 0, 0, 0, 0, 0);
        cycle("to_idle", 0, 0, 0, 0, 0);

        // memory wait over a held done
        pulse_reset("t5");
        cycle("ext_start", 0, 1, 0, 0, 0);
        cycle("ext_wait", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("ext_hold", 0, 0, 1, 0, 1);
        chk("ext.still_wait", 32'(state), 32'd1);
        cycle("ext_release", 0, 0, 1, 0, 0);
        chk("ext.idle", 32'(state), 32'd0);

        // timeout right at the limit with done arriving: done wins
        cycle("edge_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) cycle("edge_wait", 0, 0, 0, 0, 0);
        cycle("edge_done", 0, 0, 1, 0, 0);
        chk("edge.idle", 32'(state), 32'd0);

        // reset in the middle of MC_WAIT
        cycle("rst_start", 0, 1, 0, 0, 0);
        cycle("rst_wait", 0, 0, 0, 0, 0);
        pulse_reset("t6");

        // randomized legal traffic in short bursts so the counter stays informative
        for (int chunk = 0; chunk < 10; chunk++) begin
            pulse_reset("rnd");
            done_hold = 1'b0;
            for (int i = 0; i < 12; i++) begin
                r_ext = ($urandom % 6) == 0;
                r_ld  = $urandom % 2;
                r_mcs = 1'b0;
                r_br  = $urandom % 2;
                if (m_mode == 0) begin
                    done_hold = 1'b0;
                    r_mcs = ($urandom % 3) == 0;
                    if (r_mcs) r_br = 1'b0;
                end else if (m_mode == 1) begin
                    if (!done_hold) done_hold = ($urandom % 4) == 0;
                end else begin
                    done_hold = 1'b0;
                end
                cycle("rnd", r_ld, r_mcs, done_hold, r_br, r_ext);
            end
        end

        // saturation of the stall-cycle counter
        pulse_reset("t7");
        for (int i = 0; i < 20; i++) cycle("sat", 0, 0, 0, 0, 1);
        chk("sat.hold", 32'(scnt), 32'(CMAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
